sar_controller: RTL and testbench
=================================

Name: sar_controller

Overview:
- Sequencing FSM for the SAR ADC.
- Per conversion it does three things:
  - drives the sample/hold phase;
  - steps a binary-search trial code onto the reference DAC;
  - gates the dynamic latch comparator, then reads back the comparator decision bit.
- Sits between the register/control interface (start/abort, result) and the analog datapath: DAC code, comparator enable, comparator output.

Parameters:
- RESOLUTION, 12, conversion width in bits; legal 1..16.
- SAMPLE_CYCLES, 4, cycles sample_hold is asserted per conversion; legal >= 1.
- SETTLE_CYCLES, 1, DAC settle cycles per bit before the comparator is enabled; legal >= 0 (0 removes the SETTLE state).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  conversion request; sampled in IDLE or DONE.
- abort  input  1  cancel the in-flight conversion.
- comp_out  input  1  registered comparator decision; 1 = input > reference.
- comp_enable  output  1  comparator enable.
- sample_hold  output  1  high = track input, low = hold.
- dac_code  output  RESOLUTION  trial code to the reference DAC.
- busy  output  1  conversion in progress.
- done  output  1  single-cycle completion pulse.
- result  output  RESOLUTION  last completed conversion code.

Behaviour:
- Reset (synchronous, reset=1 at an edge): state=IDLE; all outputs 0, including result. Reset beats start and abort.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DECIDE, DONE. Bit index k counts from RESOLUTION-1 down to 0.
- IDLE:
  - outputs 0; result holds.
  - start=1 -> SAMPLE; working register W cleared; sample counter loaded.
- SAMPLE:
  - sample_hold=1, busy=1, for exactly SAMPLE_CYCLES cycles.
  - Exit: k=RESOLUTION-1; trial T = W with bit k set; go to SETTLE (or COMPARE if SETTLE_CYCLES=0).
- SETTLE:
  - dac_code=T, comp_enable=0, for SETTLE_CYCLES cycles -> COMPARE.
- COMPARE (1 cycle):
  - dac_code=T, comp_enable=1. The comparator registers its decision at the end of this cycle.
- DECIDE (1 cycle):
  - dac_code=T, comp_enable=0. comp_out is read this cycle.
  - comp_out=1: W bit k <= 1. comp_out=0: W bit k <= 0.
  - If k>0: k <= k-1; next T = updated W with bit k-1 set -> SETTLE/COMPARE.
  - If k=0: result <= final W -> DONE.
- DONE (1 cycle):
  - done=1, busy=0, dac_code=0; result valid from this cycle and held until the next DONE.
  - start=1 -> SAMPLE (back-to-back conversion); else -> IDLE.
- busy=1 in SAMPLE, SETTLE, COMPARE and DECIDE; 0 otherwise.
- sample_hold=1 only in SAMPLE.
- dac_code=0 outside SETTLE/COMPARE/DECIDE.
- Latency: start seen at edge E0 -> done high in cycle SAMPLE_CYCLES + RESOLUTION*(SETTLE_CYCLES+2) + 1 after E0. Defaults: 41.
- Conversion function: result = largest code strictly less than the analog input code, saturating at 0 and at 2^RESOLUTION-1. This follows from the comparator's strict ">" rule.
- start while busy: ignored; no queuing.
- abort while busy: next state IDLE; no done pulse; result unchanged; W discarded. abort beats start in the same cycle. abort in IDLE or DONE: no effect, except that it suppresses a start in the same cycle.
- Reset mid-conversion: identical to the power-on reset values.

Test Plan:
- Defaults; comparator model with input 0xA5D; pulse start -> busy rises the next cycle; trial sequence begins 0x800, 0xC00, 0xA00; done pulses at cycle 41 after start; result=0xA5C; comp_enable high exactly 12 cycles.
- Input 0x000 -> result 0x000. Input 0xFFF -> result 0xFFE. Input 0x1000 (above range) -> result 0xFFF. Check sample_hold is high for exactly 4 cycles each run.
- abort asserted in the 7th bit's COMPARE cycle -> IDLE next cycle; no done; result keeps the prior value 0xA5C. Then a fresh start completes normally.
- start held high continuously -> back-to-back conversions; done pulses every 41 cycles; start pulses while busy have no effect on timing.
- reset asserted mid-SETTLE together with start -> all outputs 0 on the next cycle, result=0. Repeat with RESOLUTION=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=0: latency = 1+4*2+1 = 10 and input 9 -> result 8.

Source files
------------

// File: rtl/sar_controller.sv
// SAR ADC sequencer: sample/hold, binary-search trial codes to the DAC, comparator gating.
// Latency SAMPLE_CYCLES + RESOLUTION*(SETTLE_CYCLES+2) + 1 from start; start ignored while busy.
module sar_controller #(
  parameter int RESOLUTION    = 12,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  comp_out,
  output logic                  comp_enable,
  output logic                  sample_hold,
  output logic [RESOLUTION-1:0] dac_code,
  output logic                  busy,
  output logic                  done,
  output logic [RESOLUTION-1:0] result
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int KW      = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [KW-1:0]    K_TOP       = KW'(RESOLUTION - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [KW-1:0]           k_q, k_d;
  logic [RESOLUTION-1:0]   w_q, w_d;
  logic [RESOLUTION-1:0]   result_q, result_d;
  logic [RESOLUTION-1:0]   k_bit;
  logic [RESOLUTION-1:0]   trial;

  // Bits below k are still zero in W, so OR-ing in bit k gives the trial code.
  always_comb begin
    k_bit = RESOLUTION'(1) << k_q;
    trial = w_q | k_bit;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    w_d         = w_q;
    result_d    = result_q;
    comp_enable = 1'b0;
    sample_hold = 1'b0;
    dac_code    = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SAMPLE;
          w_d     = '0;
          cnt_d   = SAMPLE_LOAD;
        end
      end
      S_SAMPLE: begin
        sample_hold = 1'b1;
        busy        = 1'b1;
        if (cnt_q == '0) begin
          k_d     = K_TOP;
          cnt_d   = SETTLE_LOAD;
          state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_COMPARE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        busy     = 1'b1;
        dac_code = trial;
        if (cnt_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_COMPARE: begin
        busy        = 1'b1;
        dac_code    = trial;
        comp_enable = 1'b1;
        state_d     = S_DECIDE;
      end
      S_DECIDE: begin
        busy     = 1'b1;
        dac_code = trial;
        w_d      = comp_out ? trial : w_q;
        if (k_q == '0) begin
          result_d = comp_out ? trial : w_q;
          state_d  = S_DONE;
        end else begin
          k_d     = k_q - 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_COMPARE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start && !abort) begin
          state_d = S_SAMPLE;
          w_d     = '0;
          cnt_d   = SAMPLE_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every in-flight transition, including the final result write.
    if (busy && abort) begin
      state_d  = S_IDLE;
      w_d      = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      w_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      w_q      <= w_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_sar_controller.sv
// Scoreboard bench for sar_controller: default build plus a 4-bit, no-settle build,
// each closed around a behavioural registered comparator.
module tb_sar_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, comp_out;
  logic        comp_enable, sample_hold, busy, done;
  logic [11:0] dac_code, result;
  logic [16:0] vin;

  logic        start_s, abort_s, comp_out_s;
  logic        comp_enable_s, sample_hold_s, busy_s, done_s;
  logic [3:0]  dac_code_s, result_s;
  logic [16:0] vin_s;

  sar_controller dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .comp_out(comp_out),
    .comp_enable(comp_enable), .sample_hold(sample_hold), .dac_code(dac_code),
    .busy(busy), .done(done), .result(result)
  );

  sar_controller #(.RESOLUTION(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .comp_out(comp_out_s),
    .comp_enable(comp_enable_s), .sample_hold(sample_hold_s), .dac_code(dac_code_s),
    .busy(busy_s), .done(done_s), .result(result_s)
  );

  // Latch comparators: decision registered at the end of the enabled cycle.
  always @(posedge clk) begin
    if (reset) comp_out <= 1'b0;
    else if (comp_enable) comp_out <= (vin > 17'(dac_code));
  end
  always @(posedge clk) begin
    if (reset) comp_out_s <= 1'b0;
    else if (comp_enable_s) comp_out_s <= (vin_s > 17'(dac_code_s));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] res;
    int          done_cyc;
    int          ce_n;
    int          sh_n;
  } exp_t;

  exp_t q_big[$];
  exp_t q_small[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop expectations whenever a done pulse appears.
  int          ce_big = 0, sh_big = 0, ce_small = 0, sh_small = 0;
  logic        sh_prev_big = 1'b0, sh_prev_small = 1'b0;
  logic [11:0] trials[$];

  always @(negedge clk) begin : mon_big
    exp_t e;
    if (done) begin
      if (q_big.size() == 0) flag("unexpected_done");
      else begin
        e = q_big.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("done_cycle", cyc, e.done_cyc);
        chk("comp_enable_cycles", ce_big, e.ce_n);
        chk("sample_hold_cycles", sh_big, e.sh_n);
      end
    end
    if (sample_hold && !sh_prev_big) begin
      ce_big = 0;
      sh_big = 0;
      trials.delete();
    end
    if (sample_hold) sh_big++;
    if (comp_enable) begin
      ce_big++;
      trials.push_back(dac_code);
    end
    sh_prev_big = sample_hold;
  end

  always @(negedge clk) begin : mon_small
    exp_t e;
    if (done_s) begin
      if (q_small.size() == 0) flag("unexpected_done_small");
      else begin
        e = q_small.pop_front();
        chk("result_small", 32'(result_s), 32'(e.res));
        chk("done_cycle_small", cyc, e.done_cyc);
        chk("comp_enable_cycles_small", ce_small, e.ce_n);
        chk("sample_hold_cycles_small", sh_small, e.sh_n);
      end
    end
    if (sample_hold_s && !sh_prev_small) begin
      ce_small = 0;
      sh_small = 0;
    end
    if (sample_hold_s) sh_small++;
    if (comp_enable_s) ce_small++;
    sh_prev_small = sample_hold_s;
  end

  task automatic run_big(input logic [16:0] v, input logic [11:0] exp_res);
    exp_t e;
    int   n;
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    e.res = 16'(exp_res); e.done_cyc = cyc + 41; e.ce_n = 12; e.sh_n = 4;
    q_big.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) flag("done_timeout");
  endtask

  task automatic run_small(input logic [16:0] v, input logic [3:0] exp_res);
    exp_t e;
    int   n;
    @(negedge clk);
    vin_s   = v;
    start_s = 1'b1;
    e.res = 16'(exp_res); e.done_cyc = cyc + 10; e.ce_n = 4; e.sh_n = 1;
    q_small.push_back(e);
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (!done_s && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done_s) flag("done_timeout_small");
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int seen, dn, base;
    exp_t e;
    reset = 1'b1; start = 1'b0; abort = 1'b0; vin = '0;
    start_s = 1'b0; abort_s = 1'b0; vin_s = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sample_hold", 32'(sample_hold), 32'd0);
    chk("rst_comp_enable", 32'(comp_enable), 32'd0);
    chk("rst_dac_code", 32'(dac_code), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset = 1'b0;

    run_big(17'h0000, 12'h000);
    run_big(17'h0FFF, 12'hFFE);
    run_big(17'h1000, 12'hFFF);
    run_big(17'h0A5D, 12'hA5C);
    chk("trial_count", trials.size(), 32'd12);
    if (trials.size() >= 3) begin
      chk("trial0", 32'(trials[0]), 32'h800);
      chk("trial1", 32'(trials[1]), 32'hC00);
      chk("trial2", 32'(trials[2]), 32'hA00);
    end

    // Abort in the 7th bit's COMPARE cycle.
    @(negedge clk);
    vin = 17'h0123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && seen < 7; i++) begin
      @(negedge clk);
      if (comp_enable) seen++;
    end
    chk("abort_reached_bit7", seen, 32'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dac_code", 32'(dac_code), 32'd0);
    chk("abort_comp_enable", 32'(comp_enable), 32'd0);
    repeat (50) @(negedge clk);
    chk("abort_result_held", 32'(result), 32'hA5C);
    run_big(17'h05A5, 12'h5A4);

    // start held high: three back-to-back conversions 41 cycles apart.
    @(negedge clk);
    vin = 17'h0300; start = 1'b1; base = cyc;
    for (int i = 1; i <= 3; i++) begin
      e.res = 16'h2FF; e.done_cyc = base + 41 * i; e.ce_n = 12; e.sh_n = 4;
      q_big.push_back(e);
    end
    dn = 0;
    for (int i = 0; i < 200 && dn < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    start = 1'b0;
    if (dn < 3) flag("b2b_timeout");
    @(negedge clk);
    chk("b2b_idle_after", 32'(busy), 32'd0);

    // Reset with start during the first SETTLE cycle.
    @(negedge clk);
    vin = 17'h0777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && !sample_hold && !comp_enable) break;
    end
    chk("settle_dac_code", 32'(dac_code), 32'h800);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dac_code", 32'(dac_code), 32'd0);
    chk("mid_rst_sample_hold", 32'(sample_hold), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    chk("mid_rst_start_ignored", 32'(busy), 32'd0);

    run_small(17'd9, 4'd8);
    run_small(17'd15, 4'd14);
    run_small(17'd0, 4'd0);
    run_small(17'd16, 4'd15);

    repeat (3) @(negedge clk);
    chk("big_queue_drained", q_big.size(), 32'd0);
    chk("small_queue_drained", q_small.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
